arbiter_wrr: RTL
================

# arbiter_wrr

Weighted, work-conserving round-robin arbiter with burst hold, parametrised in requester count and weight width. It sits between NUM_OF_CORES request sources and a shared downstream resource, such as a memory port or an interconnect slave. Each winner keeps the grant for up to `weight` accepted transfers (valid/ready handshake) before priority rotates past it. It supersedes the single-cycle round-robin arbiter wherever bursts must not be interleaved.

## Interface
Parameters:
- NUM_REQ, default NUM_OF_CORES (4): number of requesters, ≥ 2.
- WEIGHT_W, default 4: width of each per-requester weight.
- ID_W, default $clog2(NUM_REQ): width of the binary grant index.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  request vector, level-sensitive; bit i = requester i.
- weight  in  NUM_REQ*WEIGHT_W  per-requester burst quota; slice i = [i*WEIGHT_W +: WEIGHT_W].
- gnt_ready  in  1  downstream accepts the current transfer.
- gnt  out  NUM_REQ  one-hot grant, registered.
- gnt_id  out  ID_W  binary index of gnt, registered.
- gnt_valid  out  1  a grant is active (gnt != 0).
- gnt_last  out  1  current transfer is the final one of the burst (credit == 1).

## Operation
- The FSM has two states: IDLE and BUSY.
- Registered state:
  - `last_id` is the previous winner.
  - `credit` is WEIGHT_W bits and holds the transfers remaining.
- Pick function (combinational):
  - The masked request is req with bits ≤ last_id cleared.
  - The lowest set bit of the masked request wins.
  - If the masked request is empty, the lowest set bit of the unmasked req wins.
- IDLE:
  - If req != 0, register the pick into gnt/gnt_id, load credit = weight[pick], go to BUSY.
  - A weight value of 0 loads as 1.
  - Otherwise stay in IDLE with all grant outputs 0.
- BUSY:
  - A transfer occurs on any cycle with gnt_valid && gnt_ready; each transfer decrements credit.
  - The release condition is (transfer && credit == 1) OR (req[gnt_id] == 0).
  - On release, last_id ← gnt_id and the pick is evaluated with the new mask in the same cycle.
  - If the pick exists, load the new grant and credit and stay in BUSY; there is no bubble.
  - If no pick exists, clear the grant and go to IDLE.
- Weight is sampled only when a grant is loaded; changes mid-burst are ignored.
- Releasing the sole requester that still asserts req re-grants it with fresh credit (unmasked fallback).
- gnt_ready is ignored while gnt_valid = 0.
- gnt_last = gnt_valid && (credit == 1).

## Timing
- Reset values: gnt = 0, gnt_id = 0, gnt_valid = 0, gnt_last = 0, credit = 0, state = IDLE, last_id = NUM_REQ-1 (requester 0 has highest priority after reset).
- Latency from req rising in IDLE to gnt asserted: 1 cycle.
- Burst handover: the new gnt appears on the cycle after the releasing transfer; there are 0 idle cycles between bursts when other requests are pending.
- A requester dropping req mid-burst: its gnt is removed on the next edge; no further transfers are counted for it.
- Reset asserted mid-burst: all outputs are 0 on the next edge and priority returns to requester 0; the burst is not resumed.
- gnt, gnt_id, gnt_valid and gnt_last are all driven from registers or register-only logic; there is no combinational path from req or gnt_ready to outputs.

## Configuration
- ARB_WRR_WEIGHT_EN
  - Defined: weighted behaviour as described above.
  - Undefined: the weight port is unused, credit is forced to 1 at every grant, and every accepted transfer releases. This gives plain round robin, one transfer per grant, with the same handshake and 1-cycle latency.

## Structure
- Shared package arb_pkg:
  - FSM typedef arb_state_e {IDLE, BUSY}.
  - Default constants ARB_NUM_REQ = NUM_OF_CORES and ARB_WEIGHT_W = 4.
- One sub-module, arb_rr_pick: combinational masked/unmasked lowest-set-bit picker parametrised by NUM_REQ. Inputs are req and last_id; outputs are a one-hot pick, a binary index and a found flag.
- The top module holds the FSM, credit counter and output registers.

## Test plan
- Reset then req = 4'b1111, weight = all 2, gnt_ready = 1 → grants 0,0,1,1,2,2,3,3,0… with gnt_last on every second transfer and no idle cycles.
- req = 4'b0100 only, weight[2] = 3, gnt_ready toggling 1,0,1,0,1 → gnt held for 3 accepted transfers, re-granted to requester 2 immediately after.
- Requester 1 granted with weight 5; drop req[1] after 2 transfers while req[3] = 1 → gnt moves to 3 on the next edge; requester 1's remaining credit is discarded.
- weight[0] = 0, req = 4'b0011 → requester 0 gets exactly 1 transfer, then requester 1.
- Assert reset mid-burst (credit = 2) → outputs 0 on the next edge; after release with req = 4'b1010, requester 1 wins first.
- Build without ARB_WRR_WEIGHT_EN, weight = all 7, req = 4'b1111 → strict rotation 0,1,2,3 with one transfer each.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and FSM state type for the weighted round-robin arbiter
package arb_pkg;
    localparam int NUM_OF_CORES = 4;
    localparam int ARB_NUM_REQ  = NUM_OF_CORES;
    localparam int ARB_WEIGHT_W = 4;
    typedef enum logic {IDLE, BUSY} arb_state_e;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: lowest set request above last_id, falling back to lowest set request overall
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic [NUM_REQ-1:0] pick,
    output logic [ID_W-1:0]    pick_id,
    output logic               found
);
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] src;
    // mask out requesters at or below the previous winner, then isolate the lowest set bit
    always_comb begin
        masked = '0;
        for (int i = 0; i < NUM_REQ; i++) masked[i] = req[i] && (i > int'(last_id));
        src = (|masked) ? masked : req;
        pick = src & (~src + NUM_REQ'(1));
        pick_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) if (src[i]) pick_id = ID_W'(i);
        found = |req;
    end
endmodule

// File: rtl/arbiter_wrr.sv
// arbiter_wrr: weighted work-conserving round-robin arbiter with burst hold; ARB_WRR_WEIGHT_EN enables per-requester burst quotas
module arbiter_wrr
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = ARB_NUM_REQ,
    parameter int WEIGHT_W = ARB_WEIGHT_W,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WEIGHT_W-1:0]  weight,
    input  logic                         gnt_ready,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [ID_W-1:0]              gnt_id,
    output logic                         gnt_valid,
    output logic                         gnt_last
);
    arb_state_e           state, state_n;
    logic [ID_W-1:0]      last_id, last_id_n, pick_last, pick_id, gnt_id_n;
    logic [WEIGHT_W-1:0]  credit, credit_n, quota;
    logic [NUM_REQ-1:0]   pick, gnt_n;
    logic                 found, xfer, rel, load;

    assign pick_last = (state == BUSY) ? gnt_id : last_id;

    arb_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req     (req),
        .last_id (pick_last),
        .pick    (pick),
        .pick_id (pick_id),
        .found   (found)
    );

`ifdef ARB_WRR_WEIGHT_EN
    logic [NUM_REQ-1:0][WEIGHT_W-1:0] wv;
    logic [WEIGHT_W-1:0]              wsel;
    assign wv    = weight;
    assign wsel  = wv[pick_id];
    assign quota = (wsel == '0) ? WEIGHT_W'(1) : wsel;
`else
    logic unused_weight;
    assign unused_weight = ^weight;
    assign quota = WEIGHT_W'(1);
`endif

    // state, priority pointer, credit and grant registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            last_id <= ID_W'(NUM_REQ - 1);
            credit  <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
        end else begin
            state   <= state_n;
            last_id <= last_id_n;
            credit  <= credit_n;
            gnt     <= gnt_n;
            gnt_id  <= gnt_id_n;
        end
    end

    // release on final accepted transfer or dropped request; re-pick in the same cycle
    always_comb begin
        xfer      = gnt_valid && gnt_ready;
        rel       = (state == BUSY) && ((xfer && credit == WEIGHT_W'(1)) || !req[gnt_id]);
        load      = ((state == IDLE) || rel) && found;
        state_n   = load ? BUSY : (rel ? IDLE : state);
        last_id_n = rel ? gnt_id : last_id;
        gnt_n     = load ? pick : (rel ? '0 : gnt);
        gnt_id_n  = load ? pick_id : (rel ? '0 : gnt_id);
        credit_n  = load ? quota : (rel ? '0 : (xfer ? credit - WEIGHT_W'(1) : credit));
    end

    // outputs derived only from registers
    always_comb begin
        gnt_valid = |gnt;
        gnt_last  = gnt_valid && (credit == WEIGHT_W'(1));
    end
endmodule
